bus_uart_tx: RTL and testbench
==============================

# bus_uart_tx

Memory-mapped UART transmitter on the riscv_core data bus, alongside ram. Decodes two word registers at BASE_ADDR and buffers written bytes in a small FIFO. It serialises the bytes as 8N1 frames on a single `tx` line. Software polls STATUS to avoid overflow.

## Interface
- BASE_ADDR, 32'h0000_1000: word-aligned base address of the register pair.
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be ≥ 2.
- FIFO_DEPTH, 4: byte FIFO entries. Must be a power of two, ≥ 2.

- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_address  in  32  core data-bus address.
- bus_write  in  1  write strobe, sampled at rising edge.
- bus_write_data  in  32  write data.
- bus_read  in  1  read strobe.
- bus_read_data  out  32  combinational read data.
- tx  out  1  serial output, registered, idle high.

## Operation
- Decode compares bus_address[31:2] with BASE_ADDR[31:2]; bus_address[1:0] are ignored.
  - Offset 0 (TXDATA) is selected when bus_address[2]=0.
  - Offset 4 (STATUS) is selected when bus_address[2]=1.
- TXDATA write: push bus_write_data[7:0] if FIFO not full. TXDATA read returns 0.
- STATUS read fields:
  - bit0 full, bit1 empty, bit2 busy, bit3 overflow.
  - bits[7:4] FIFO count, saturating at 15.
  - All other bits 0.
- STATUS write: bit3=1 clears overflow. Other bits are ignored.
- bus_read_data is nonzero only when bus_read=1 and the address hits. Otherwise it is 32'h0.
- Full is evaluated before the edge. A TXDATA write while full is dropped and sets overflow (sticky), even if a pop occurs on the same edge.
- If overflow set and clear happen on the same edge, set wins.
- busy = (state != IDLE) | !empty.
- FSM states:
  - IDLE: tx=1. If FIFO not empty, pop the head into the shift register, go to START, clear baud_cnt.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0], LSB first. After CLKS_PER_BIT cycles, shift right and increment bit_idx. After bit_idx 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the last cycle, if FIFO not empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- FIFO behaviour:
  - Circular; pointers are log2(FIFO_DEPTH) bits and wrap. Count is log2(FIFO_DEPTH)+1 bits.
  - Push and pop on the same edge (not full) leave count unchanged.
- tx is registered. Its value reflects the state entered at the preceding edge.

## Timing
- Reset values: tx=1, state IDLE, FIFO empty (count 0), overflow 0, baud_cnt 0, bit_idx 0. With bus_read=0, bus_read_data=0.
- Reset mid-frame: at the next edge tx=1, the frame is aborted, the FIFO is flushed, and overflow is cleared. No partial frame resumes.
- Write to TXDATA at edge N into an empty, IDLE block:
  - FIFO count=1 after N.
  - Pop at N+1; tx=0 after N+1.
  - Start bit spans edges N+1..N+1+CLKS_PER_BIT.
- Frame length is exactly 10×CLKS_PER_BIT cycles. Consecutive queued bytes are contiguous.
- Bus reads are combinational, with zero-cycle latency. STATUS reflects the registered state before the current edge.
- Bus writes take effect at the edge where bus_write=1. They are visible in STATUS in the following cycle.

## Test plan
- Reset:
  - Stimulus: hold reset 1 cycle, then read STATUS.
  - Required: 32'h0000_0002 (empty), tx=1.
- Single byte:
  - Stimulus: CLKS_PER_BIT=4, write 0xA5 to TXDATA.
  - Required: tx samples every 4 cycles from the edge after the write are 0,1,0,1,0,0,1,0,1,1. That is 40 cycles, after which busy=0.
- Back-to-back:
  - Stimulus: write 0x00 then 0xFF on consecutive cycles.
  - Required: 80-cycle contiguous waveform with no idle cycle between the first stop bit and the second start bit.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, CLKS_PER_BIT=16. Write 6 bytes on consecutive cycles.
  - Required: first byte popped, 4 queued, sixth write dropped. STATUS reads full=1, overflow=1, count=4.
  - Follow-up: write STATUS 0x8. Overflow reads 0 next cycle.
- Decode:
  - Stimulus: write 0x41 to BASE_ADDR+8, and to BASE_ADDR+1.
  - Required: BASE_ADDR+8 is ignored (count stays 0). BASE_ADDR+1 aliases to TXDATA (count 1).
  - Required: a read with bus_read=0 returns 0.
- Reset mid-frame:
  - Stimulus: assert reset at cycle 13 of a 40-cycle frame, with 2 bytes queued.
  - Required: tx=1 next cycle, STATUS=0x2, no further frames.

Source files
------------

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register pair, byte FIFO,
// and a serialiser that chains queued bytes with no idle gap between frames.
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic        bus_write,
  input  logic [31:0] bus_write_data,
  input  logic        bus_read,
  output logic [31:0] bus_read_data,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t         r_state;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;

  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_ovf;

  logic [29:0]    w_word;
  logic           w_hit;
  logic           w_sel_status;
  logic           w_full;
  logic           w_empty;
  logic           w_wr_txdata;
  logic           w_wr_status;
  logic           w_push;
  logic           w_pop;
  logic           w_baud_last;
  logic           w_busy;
  logic [7:0]     w_head;
  logic [31:0]    w_cnt32;
  logic [3:0]     w_cnt_sat;
  logic [31:0]    w_status;
  logic           w_unused;

  // Word offset from the base; only words 0 (TXDATA) and 1 (STATUS) hit,
  // byte-offset bits are ignored so BASE+1..3 alias TXDATA.
  assign w_word       = bus_address[31:2] - BASE_ADDR[31:2];
  assign w_hit        = (w_word[29:1] == '0);
  assign w_sel_status = w_word[0];

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_wr_txdata = bus_write & w_hit & ~w_sel_status;
  assign w_wr_status = bus_write & w_hit & w_sel_status;
  assign w_push      = w_wr_txdata & ~w_full;
  assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) |
                                   ((r_state == S_STOP) & w_baud_last));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_busy      = (r_state != S_IDLE) | ~w_empty;

  assign w_cnt32   = 32'(r_count);
  assign w_cnt_sat = (w_cnt32 > 32'd15) ? 4'hF : w_cnt32[3:0];
  assign w_status  = {24'h0, w_cnt_sat, r_ovf, w_busy, w_empty, w_full};

  assign bus_read_data = (bus_read & w_hit & w_sel_status) ? w_status : 32'h0;
  assign tx            = r_tx;

  assign w_unused = ^{bus_address[1:0], bus_write_data[31:8]};

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus_write_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // A dropped write outranks a same-edge clear.
      if (w_wr_txdata & w_full)
        r_ovf <= 1'b1;
      else if (w_wr_status & bus_write_data[3])
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_baud  <= '0;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            // Chain straight into the next start bit when more data waits.
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: fixed vectors, directed frame/overflow/reset sequences
// and random traffic checked against a frame-level reference model.
module tb_bus_uart_tx;

  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [31:0] bus_write_data;
  logic        bus_read;
  logic [31:0] bus_read_data;
  logic        tx;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_seen;

  bus_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) u_dut (
    .clock(clock), .reset(reset), .bus_address(bus_address),
    .bus_write(bus_write), .bus_write_data(bus_write_data),
    .bus_read(bus_read), .bus_read_data(bus_read_data), .tx(tx)
  );

  always #5 clock = ~clock;

  // Reference model: a byte queue plus the frame currently on the line.
  logic [7:0] m_q[$];
  bit         m_active;
  logic [9:0] m_frame;
  int         m_pos;
  bit         m_ovf;

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    logic [3:0] c4 = (n > 15) ? 4'hF : 4'(n);
    return {24'h0, c4, m_ovf, (m_active || n != 0), (n == 0), (n == D)};
  endfunction

  function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
    if (!rd || a[31:3] != BASE[31:3] || !a[2]) return 32'h0;
    return m_status();
  endfunction

  function automatic logic m_tx();
    return m_active ? m_frame[m_pos / C] : 1'b1;
  endfunction

  task automatic m_step(input logic rst, wr, input logic [31:0] a, wd);
    bit hit, txw, stw, full, last, do_pop;
    logic [7:0] b;
    if (rst) begin
      m_q.delete(); m_active = 0; m_pos = 0; m_ovf = 0;
      return;
    end
    hit    = (a[31:3] == BASE[31:3]);
    txw    = wr && hit && !a[2];
    stw    = wr && hit && a[2];
    full   = (m_q.size() == D);
    last   = m_active && (m_pos == 10 * C - 1);
    do_pop = (!m_active || last) && (m_q.size() > 0);
    if (last && !do_pop) m_active = 0;
    if (txw && full) m_ovf = 1;
    else if (stw && wd[3]) m_ovf = 0;
    if (txw && !full) m_q.push_back(wd[7:0]);
    if (do_pop) begin
      b = m_q.pop_front();
      m_frame = {1'b1, b, 1'b0};
      m_pos = 0;
      m_active = 1;
    end else if (m_active) begin
      m_pos++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle, entered and left at a falling edge.
  task automatic cycle(input logic rst, wr, rd, input logic [31:0] a, wd);
    reset = rst; bus_write = wr; bus_read = rd; bus_address = a; bus_write_data = wd;
    #1;
    rd_seen = bus_read_data;
    chk("model_rdata", rd_seen, m_read(rd, a));
    @(posedge clock);
    m_step(rst, wr, a, wd);
    @(negedge clock);
    chk("model_tx", {31'h0, tx}, {31'h0, m_tx()});
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    cycle(1'b0, 1'b0, 1'b1, BASE + 32'd4, 32'h0);
    chk(name, rd_seen, exp);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_tx;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    logic [9:0]  a5_bits;
    logic [19:0] bb_bits;
    logic [31:0] addrs[8];
    int          burst;

    vt[0] = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,  32'h2,  1'b1};
    vt[1] = '{1'b0, 1'b1, BASE,          32'h0,  32'h0,  1'b1};
    vt[2] = '{1'b0, 1'b0, BASE + 32'd4,  32'h0,  32'h0,  1'b1};
    vt[3] = '{1'b0, 1'b1, BASE + 32'd12, 32'h0,  32'h0,  1'b1};
    vt[4] = '{1'b1, 1'b1, BASE + 32'd8,  32'h41, 32'h0,  1'b1};
    vt[5] = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,  32'h2,  1'b1};
    vt[6] = '{1'b1, 1'b1, BASE + 32'd1,  32'h41, 32'h0,  1'b1};
    vt[7] = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,  32'h14, 1'b0};
    vt[8] = '{1'b0, 1'b1, BASE + 32'd7,  32'h0,  32'h6,  1'b0};

    m_active = 0; m_pos = 0; m_ovf = 0; m_frame = '1;
    @(negedge clock);
    do_reset();
    chk("reset_tx", {31'h0, tx}, 32'h1);
    read_status("reset_status", 32'h2);

    do_reset();
    foreach (vt[i]) begin
      cycle(1'b0, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata);
      chk("vec_rdata", rd_seen, vt[i].exp_rd);
      chk("vec_tx", {31'h0, tx}, {31'h0, vt[i].exp_tx});
    end

    // Single 0xA5 frame, sampled once per bit period.
    do_reset();
    a5_bits = 10'b1101001010;
    cycle(1'b0, 1'b1, 1'b0, BASE, 32'hA5);
    for (int k = 0; k < 40; k++) begin
      idle(1);
      if (k % 4 == 0) chk("a5_bit", {31'h0, tx}, {31'h0, a5_bits[k/4]});
    end
    read_status("a5_last_stop", 32'h6);
    read_status("a5_done", 32'h2);

    // 0x00 then 0xFF: one contiguous 80-cycle waveform.
    do_reset();
    bb_bits = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    cycle(1'b0, 1'b1, 1'b0, BASE, 32'h00);
    cycle(1'b0, 1'b1, 1'b0, BASE, 32'hFF);
    chk("b2b_wave", {31'h0, tx}, {31'h0, bb_bits[0]});
    for (int k = 1; k < 80; k++) begin
      idle(1);
      chk("b2b_wave", {31'h0, tx}, {31'h0, bb_bits[k/4]});
    end
    idle(1);
    read_status("b2b_done", 32'h2);

    // Six writes into a depth-4 FIFO: one popped, four queued, one dropped.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, BASE, 32'(i + 1));
    read_status("ovf_status", 32'h4D);
    cycle(1'b0, 1'b1, 1'b1, BASE + 32'd4, 32'h8);
    chk("ovf_clr_same", rd_seen, 32'h4D);
    read_status("ovf_cleared", 32'h45);
    idle(200);
    read_status("ovf_drained", 32'h2);

    // Reset in the middle of a frame with two bytes still queued.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, BASE, 32'h3C);
    idle(10);
    do_reset();
    chk("midrst_tx", {31'h0, tx}, 32'h1);
    read_status("midrst_status", 32'h2);
    for (int k = 0; k < 60; k++) begin
      idle(1);
      chk("midrst_quiet", {31'h0, tx}, 32'h1);
    end

    // Random traffic, alternating sparse and bursty write phases.
    addrs = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd1,
              BASE + 32'd5, BASE + 32'd12, 32'h0000_2000, BASE - 32'd4};
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rst_r, wr_r, rd_r;
      logic [31:0] a_r;
      burst = (i / 500) % 2;
      rst_r = ($urandom_range(0, 699) == 0);
      wr_r  = burst ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 23) == 0);
      rd_r  = $urandom_range(0, 1) == 1;
      a_r   = ($urandom_range(0, 2) == 0) ? addrs[$urandom_range(0, 7)] :
              (wr_r ? BASE : BASE + 32'd4);
      cycle(rst_r, wr_r, rd_r, a_r, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
